fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation core. It replaces the single-cycle PC register and combinational ROM read with a stateful fetch path:
- PC sequencer driving a req/ack instruction-memory handshake with one outstanding request;
- prefetch FIFO feeding decode through valid/ready;
- branch (PC-relative) and jump (absolute) redirect with flush and discard of in-flight data.

Sits between instruction memory and the control unit / register file.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 53 +++++
 rtl/fetch_unit_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds FSM encodings and instruction field positions.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DISCARD
  } state_t;

  localparam int DEF_INSTR_BYTES = 2;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  function automatic logic [3:0] opcode_of(
    input logic [15:0] instr
  );
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: imem handshake, decode handshake and redirect.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_next;

  logic               redirect_valid;
  logic               redirect_branch;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [7:0]         redirect_imm;
  logic [ADDR_W-1:0]  redirect_target;

  logic [CW-1:0]      fifo_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output out_valid, out_instr,
    output out_pc, out_pc_next,
    input  out_ready,
    input  redirect_valid, redirect_branch,
    input  redirect_pc, redirect_imm,
    input  redirect_target,
    output fifo_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  out_valid, out_instr,
    input  out_pc, out_pc_next,
    output out_ready,
    output redirect_valid, redirect_branch,
    output redirect_pc, redirect_imm,
    output redirect_target,
    input  fifo_count
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO with flush and a registered head.
// Payload is opaque: {instr, pc_next, pc} from the fetch unit.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  wptr_n;
  logic [AW:0]  rptr_n;

  assign wptr_n = wptr + (AW+1)'(push);
  assign rptr_n = rptr + (AW+1)'(pop);
  assign count  = wptr - rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  // Head register looks ahead so it is valid the cycle after a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      rdata <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      valid <= wptr_n != rptr_n;
      if (push && rptr_n == wptr)
        rdata <= wdata;
      else
        rdata <= mem[rptr_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencer, imem req/ack,
// prefetch FIFO and branch/jump redirect with in-flight discard.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 16,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_unit_if.master bus
);

  localparam int SH = $clog2(INSTR_BYTES);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = INSTR_W + 2 * ADDR_W;
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN =
    ~ADDR_W'(INSTR_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target;
  logic              ack;
  logic              push;
  logic              pop;
  logic              head_valid;
  logic [PW-1:0]     head;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_after;

  assign ack  = bus.imem_req & bus.imem_ack;
  assign push = ack & (state == S_FETCH)
              & ~bus.redirect_valid;
  assign pop  = head_valid & bus.out_ready;

  assign count_after = count + CW'(push) - CW'(pop);
  assign pc_inc      = fetch_pc + STEP;

  assign offset = {{(ADDR_W-8){bus.redirect_imm[7]}},
                   bus.redirect_imm} << SH;

  always_comb begin
    target = bus.redirect_target & ALIGN;
    if (bus.redirect_branch)
      target = bus.redirect_pc + STEP + offset;
  end

  fetch_unit_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (push),
    .wdata ({bus.imem_rdata, pc_inc, fetch_pc}),
    .pop   (pop),
    .valid (head_valid),
    .rdata (head),
    .count (count)
  );

  assign bus.out_valid = head_valid;
  assign {bus.out_instr, bus.out_pc_next, bus.out_pc} = head;
  assign bus.fifo_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
    end else begin
      unique case (state)
        S_IDLE: begin
          state         <= S_FETCH;
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= fetch_pc;
        end
        S_FETCH: begin
          if (bus.redirect_valid) begin
            fetch_pc <= target;
            if (ack) bus.imem_addr <= target;
            else     state <= S_DISCARD;
          end else if (ack) begin
            fetch_pc      <= pc_inc;
            bus.imem_addr <= pc_inc;
            if (count_after == CW'(DEPTH)) begin
              state        <= S_HOLD;
              bus.imem_req <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            fetch_pc      <= target;
            bus.imem_addr <= target;
            state         <= S_FETCH;
            bus.imem_req  <= 1'b1;
          end else if (count_after < CW'(DEPTH)) begin
            state        <= S_FETCH;
            bus.imem_req <= 1'b1;
          end
        end
        S_DISCARD: begin
          // Stale address stays on the bus until its ack.
          if (bus.redirect_valid) fetch_pc <= target;
          if (ack) begin
            state         <= S_FETCH;
            bus.imem_addr <= bus.redirect_valid
                           ? target : fetch_pc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory latency,
// decode stalls and redirects against a PC-stream model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4)) bus0();
  fetch_unit_if #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4)) bus1();

  fetch_unit #(.RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  fetch_unit #(.RESET_PC(16'hFFFC)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'd3;
    return m ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Zero-wait memory for the RESET_PC=0xFFFC instance.
  assign bus1.imem_ack        = bus1.imem_req;
  assign bus1.imem_rdata      = mem_word(bus1.imem_addr);
  assign bus1.out_ready       = 1'b1;
  assign bus1.redirect_valid  = 1'b0;
  assign bus1.redirect_branch = 1'b0;
  assign bus1.redirect_pc     = '0;
  assign bus1.redirect_imm    = '0;
  assign bus1.redirect_target = '0;

  // Memory responder with random latency; checks req/addr hold.
  int lat_min = 0;
  int lat_max = 0;
  int lat;
  bit pending;
  bit first_req;
  logic [15:0] paddr;

  initial begin
    bus0.imem_ack   = 1'b0;
    bus0.imem_rdata = '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      bus0.imem_ack = 1'b0;
      pending = 1'b0;
      first_req = 1'b1;
    end else begin
      bus0.imem_ack = 1'b0;
      if (bus0.imem_req) begin
        if (!pending) begin
          pending = 1'b1;
          paddr = bus0.imem_addr;
          lat = $urandom_range(lat_max, lat_min);
          if (first_req) chk("first_addr", paddr, 0);
          first_req = 1'b0;
        end else begin
          chk("addr_hold", bus0.imem_addr, paddr);
        end
        if (lat == 0) begin
          bus0.imem_ack = 1'b1;
          bus0.imem_rdata = mem_word(paddr);
          pending = 1'b0;
        end else begin
          lat--;
        end
      end else if (pending) begin
        chk("req_hold", 0, 1);
        pending = 1'b0;
      end
    end
  end

  // Reference: decode sees a sequential PC stream restarted
  // at every redirect target.
  logic [15:0] model_pc;
  logic [15:0] exp_q[$];

  task automatic model_restart(input logic [15:0] pc);
    exp_q.delete();
    model_pc = pc;
  endtask

  initial begin : monitor
    bit prev_redir;
    logic [15:0] e;
    logic [15:0] en;
    prev_redir = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_redir = 1'b0;
        continue;
      end
      if (prev_redir) begin
        chk("flush_cnt", bus0.fifo_count, 0);
        chk("flush_vld", bus0.out_valid, 0);
      end
      prev_redir = bus0.redirect_valid;
      if (bus0.out_valid && bus0.out_ready
          && !bus0.redirect_valid) begin
        while (exp_q.size() < 4) begin
          exp_q.push_back(model_pc);
          model_pc = model_pc + 16'd2;
        end
        e  = exp_q.pop_front();
        en = e + 16'd2;
        chk("out_pc", bus0.out_pc, e);
        chk("out_instr", bus0.out_instr, mem_word(e));
        chk("out_pc_next", bus0.out_pc_next, en);
      end
    end
  end

  initial begin : dut1_chk
    logic [15:0] e1;
    logic [15:0] e1n;
    int n;
    e1 = 16'hFFFC;
    n = 0;
    @(negedge rst);
    for (int i = 0; i < 20 && n < 6; i++) begin
      @(negedge clk);
      #2;
      if (bus1.out_valid) begin
        e1n = e1 + 16'd2;
        chk("wrap_pc", bus1.out_pc, e1);
        chk("wrap_pc_next", bus1.out_pc_next, e1n);
        e1 = e1n;
        n++;
      end
    end
    if (n < 6) chk("wrap_timeout", n, 6);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", bus0.imem_req, 0);
    chk("rst_addr", bus0.imem_addr, 0);
    chk("rst_valid", bus0.out_valid, 0);
    chk("rst_instr", bus0.out_instr, 0);
    chk("rst_pc", bus0.out_pc, 0);
    chk("rst_pc_next", bus0.out_pc_next, 0);
    chk("rst_count", bus0.fifo_count, 0);
    chk("rst1_addr", bus1.imem_addr, 16'hFFFC);
    tick();
    tick();
    model_restart(16'h0000);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input bit br,
                             input logic [15:0] pc,
                             input logic [7:0] imm,
                             input logic [15:0] tgt);
    logic rdy;
    int t;
    rdy = bus0.out_ready;
    bus0.out_ready       = 1'b0;
    bus0.redirect_valid  = 1'b1;
    bus0.redirect_branch = br;
    bus0.redirect_pc     = pc;
    bus0.redirect_imm    = imm;
    bus0.redirect_target = tgt;
    if (br) t = int'(pc) + 2 + 2 * int'(signed'(imm));
    else    t = int'(tgt) - (int'(tgt) % 2);
    model_restart(16'(t));
    tick();
    bus0.redirect_valid = 1'b0;
    bus0.out_ready = rdy;
  endtask

  task automatic wait_pending(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus0.imem_req && !bus0.imem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("pending_timeout", 0, 1);
  endtask

  initial begin : main
    bit ok;
    bus0.out_ready       = 1'b1;
    bus0.redirect_valid  = 1'b0;
    bus0.redirect_branch = 1'b0;
    bus0.redirect_pc     = '0;
    bus0.redirect_imm    = '0;
    bus0.redirect_target = '0;
    model_restart(16'h0000);
    tick();

    // Sequential zero-wait run; first instruction latency.
    lat_min = 0; lat_max = 0;
    do_reset();
    repeat (3) tick();
    chk("latency", bus0.out_valid, 1);
    repeat (20) tick();

    // Decode stall fills the FIFO and parks the requester.
    do_reset();
    bus0.out_ready = 1'b0;
    repeat (12) tick();
    chk("sat_count", bus0.fifo_count, 4);
    chk("sat_req", bus0.imem_req, 0);
    chk("sat_valid", bus0.out_valid, 1);
    bus0.out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_req", bus0.imem_req, 1);
    repeat (12) tick();

    // Branch while a slow request is outstanding.
    lat_min = 3; lat_max = 3;
    wait_pending(ok);
    do_redirect(1'b1, 16'h0010, 8'hFD, 16'h0000);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.imem_ack) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("stale_ack_timeout", 0, 1);
    tick();
    chk("br_req", bus0.imem_req, 1);
    chk("br_addr", bus0.imem_addr, 16'h000C);
    repeat (25) tick();

    // Jump in the same cycle as an ack.
    lat_min = 0; lat_max = 0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus0.imem_ack) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ack_timeout", 0, 1);
    do_redirect(1'b0, 16'h0000, 8'h00, 16'h1235);
    chk("jmp_count", bus0.fifo_count, 0);
    chk("jmp_req", bus0.imem_req, 1);
    chk("jmp_addr", bus0.imem_addr, 16'h1234);
    repeat (15) tick();

    // Random latency, stalls and redirects.
    lat_min = 0; lat_max = 3;
    for (int c = 0; c < 2500; c++) begin
      bus0.out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 24) == 0) begin
        do_redirect($urandom_range(0, 1) == 1,
                    16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE,
                    8'($urandom_range(0, 255)),
                    16'($urandom_range(0, 16'hFFFF)));
      end else begin
        tick();
      end
    end

    // Reset while a request is waiting for its ack.
    lat_min = 2; lat_max = 3;
    bus0.out_ready = 1'b0;
    wait_pending(ok);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", bus0.imem_req, 0);
    chk("mid_rst_valid", bus0.out_valid, 0);
    chk("mid_rst_count", bus0.fifo_count, 0);
    tick();
    tick();
    model_restart(16'h0000);
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
